// File: rtl/ifetch_pkg.sv
// Shared widths and the fetch-queue entry layout for the instruction fetch unit.
package ifetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;
  localparam int unsigned QDEPTH     = 2;
  localparam int unsigned ENTRY_W    = 2 * XLEN;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  // One queued fetch: instruction word (upper half) and its byte address.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Two-entry FIFO holding fetched {inst, pc} pairs between imem and decode.
// Ports:
//   clk, rst_n  clock, async active-low reset (clears entries, pointers, count)
//   flush_i     drop all entries and reset pointers; overrides write and read
//   wr_en_i     push wr_data_i
//   wr_data_i   packed fetch_entry_t
//   rd_en_i     pop head
//   head_o      entry at the read pointer
//   count_o     number of valid entries (0..2)
module ifetch_queue
  import ifetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               wr_en_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  input  logic               rd_en_i,
  output logic [ENTRY_W-1:0] head_o,
  output logic [1:0]         count_o
);

  logic [ENTRY_W-1:0] mem_q [QDEPTH];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               do_wr, do_rd;

  // Pointer/count update; flush wins over any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_wr    = wr_en_i & ~flush_i & (count_q != 2'(QDEPTH));
    do_rd    = rd_en_i & ~flush_i & (count_q != 2'd0);
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_wr) wr_ptr_d = ~wr_ptr_q;
      if (do_rd) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(do_wr) - 2'(do_rd);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < int'(QDEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: drives the word address of a 1-cycle synchronous imem,
// buffers responses in a 2-entry queue for decode, and flushes on PC redirect.
// Ports:
//   clk, rst_n      clock, async active-low reset (restart from RESET_PC)
//   imem_addr       word index presented to imem (combinational)
//   imem_rdata      imem data for the address presented the previous cycle
//   redirect_valid  load redirect_pc this cycle, dropping queued/in-flight fetches
//   redirect_pc     target byte address; low two bits ignored
//   inst_valid      queue head valid (combinational; forced low during redirect)
//   inst_ready      decode takes the head this cycle
//   inst, inst_pc   head instruction and its byte address
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]    resp_pc_q, resp_pc_d;
  logic               inflight_q, inflight_d;
  logic [XLEN-1:0]    redir_tgt;
  logic [1:0]         redirect_lsb_unused;
  logic [1:0]         count;
  logic [2:0]         occupancy;
  logic               pop, issue, resp_wr;
  fetch_entry_t       wr_entry, head;
  logic [ENTRY_W-1:0] head_raw;

  assign redir_tgt           = {redirect_pc[XLEN-1:2], 2'b00};
  assign redirect_lsb_unused = redirect_pc[1:0];

  assign inst_valid = (count != 2'd0) & ~redirect_valid;
  assign pop        = inst_valid & inst_ready;

  // Slots committed after this edge; a new request only fits if one stays free.
  assign occupancy = 3'(count) + 3'(inflight_q) - 3'(pop);
  assign issue     = (occupancy < 3'd2) | redirect_valid;

  // A response landing in a redirect cycle belongs to the old stream.
  assign resp_wr       = inflight_q & ~redirect_valid;
  assign wr_entry.inst = imem_rdata;
  assign wr_entry.pc   = resp_pc_q;

  // Request address and PC bookkeeping.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = 1'b0;
    imem_addr  = {2'b00, fetch_pc_q[XLEN-1:2]};
    if (redirect_valid) begin
      imem_addr  = {2'b00, redirect_pc[XLEN-1:2]};
      resp_pc_d  = redir_tgt;
      fetch_pc_d = redir_tgt + XLEN'(INST_BYTES);
      inflight_d = 1'b1;
    end else if (issue) begin
      resp_pc_d  = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
    end
  end

  ifetch_queue u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (redirect_valid),
    .wr_en_i   (resp_wr),
    .wr_data_i (wr_entry),
    .rd_en_i   (pop),
    .head_o    (head_raw),
    .count_o   (count)
  );

  assign head    = fetch_entry_t'(head_raw);
  assign inst    = head.inst;
  assign inst_pc = head.pc;

  // Queue plus outstanding request never exceeds the two buffer slots.
  a_occupancy: assert property (@(posedge clk) disable iff (!rst_n)
    (3'(count) + 3'(inflight_q)) <= 3'd2);

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;

  // Second instance exercising PC wrap from a high reset address.
  logic [31:0] w_imem_addr, w_imem_rdata;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = '0;
  logic        w_inst_valid;
  logic        w_inst_ready = 1'b1;
  logic [31:0] w_inst, w_inst_pc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ifetch dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  ifetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .inst_valid(w_inst_valid), .inst_ready(w_inst_ready), .inst(w_inst), .inst_pc(w_inst_pc)
  );

  // imem: registered read, mem[i] = 0x1000_0000 + i
  always @(posedge clk) begin
    imem_rdata   <= 32'h1000_0000 + imem_addr;
    w_imem_rdata <= 32'h1000_0000 + w_imem_addr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs for one cycle at the falling edge, then let outputs settle.
  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n          = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(inst_valid), 32'd1);
    check({tag, "_pc"}, inst_pc, pc);
    check({tag, "_inst"}, inst, 32'h1000_0000 + (pc >> 2));
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic        r;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_w_addr", w_imem_addr, 32'h3FFF_FFFE);

    // Test 1: startup latency (cycle 0 = first cycle out of reset)
    release_reset();
    check("c0_valid", 32'(inst_valid), 32'd0);
    check("c0_addr", imem_addr, 32'd0);
    drive(1'b1, 1'b0, '0);
    check("c1_valid", 32'(inst_valid), 32'd0);
    check("c1_addr", imem_addr, 32'd1);
    drive(1'b1, 1'b0, '0);
    check_head("c2", 32'h0);
    check("w_c2_pc", w_inst_pc, 32'hFFFF_FFF8);
    check("w_c2_inst", w_inst, 32'h4FFF_FFFE);

    // Test 2: stall from cycle 3 for 5 cycles
    drive(1'b0, 1'b0, '0);
    check_head("c3", 32'h4);
    check("w_c3_pc", w_inst_pc, 32'hFFFF_FFFC);
    check("w_c3_inst", w_inst, 32'h4FFF_FFFF);
    for (int i = 4; i < 8; i++) begin
      drive(1'b0, 1'b0, '0);
      check_head("stall", 32'h4);
      check("stall_addr", imem_addr, 32'd3);
      if (i == 4) begin
        check("w_wrap_pc", w_inst_pc, 32'h0);
        check("w_wrap_inst", w_inst, 32'h1000_0000);
      end
      if (i == 5) check("w_wrap_pc2", w_inst_pc, 32'h4);
    end
    exp_pc = 32'h4;
    for (int i = 8; i < 14; i++) begin
      drive(1'b1, 1'b0, '0);
      check_head("resume", exp_pc);
      exp_pc += 32'd4;
    end

    // Test 3: redirect with a queued word and a request in flight
    drive(1'b1, 1'b1, 32'h40);
    check("r40_valid", 32'(inst_valid), 32'd0);
    check("r40_addr", imem_addr, 32'h10);
    drive(1'b1, 1'b0, '0);
    check("r40_p1_valid", 32'(inst_valid), 32'd0);
    drive(1'b1, 1'b0, '0);
    check_head("r40_p2", 32'h40);
    drive(1'b0, 1'b0, '0);
    check_head("r40_p3", 32'h44);

    // Test 4: unaligned redirect while full, then back-to-back redirects
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    check_head("full_head", 32'h44);
    drive(1'b1, 1'b1, 32'h43);
    check("r43_valid", 32'(inst_valid), 32'd0);
    check("r43_addr", imem_addr, 32'h10);
    drive(1'b1, 1'b0, '0);
    check("r43_p1_valid", 32'(inst_valid), 32'd0);
    drive(1'b1, 1'b0, '0);
    check_head("r43_p2", 32'h40);
    drive(1'b1, 1'b1, 32'h80);
    check("r80_addr", imem_addr, 32'h20);
    drive(1'b1, 1'b1, 32'hC0);
    check("rc0_valid", 32'(inst_valid), 32'd0);
    check("rc0_addr", imem_addr, 32'h30);
    drive(1'b1, 1'b0, '0);
    check("rc0_p1_valid", 32'(inst_valid), 32'd0);
    drive(1'b1, 1'b0, '0);
    check_head("rc0_p2", 32'hC0);
    drive(1'b1, 1'b0, '0);
    check_head("rc0_p3", 32'hC4);

    // Test 6: async reset mid-stream with the queue full
    repeat (3) drive(1'b0, 1'b0, '0);
    check_head("pre_rst", 32'hC8);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(inst_valid), 32'd0);
    check("mid_rst_inst", inst, 32'd0);
    check("mid_rst_pc", inst_pc, 32'd0);
    check("mid_rst_addr", imem_addr, 32'd0);
    release_reset();
    check("rr_c0_valid", 32'(inst_valid), 32'd0);
    drive(1'b1, 1'b0, '0);
    check("rr_c1_valid", 32'(inst_valid), 32'd0);
    drive(1'b1, 1'b0, '0);
    check_head("rr_c2", 32'h0);
    exp_pc = 32'h4;
    for (int i = 0; i < 40; i++) begin
      r = 1'($urandom_range(0, 1));
      drive(r, 1'b0, '0);
      check_head("rand", exp_pc);
      if (r) exp_pc += 32'd4;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
